// File: rtl/sdp_ram_neg_clr_if.sv
// Bus bundle for sdp_ram_neg_clr: write port, read port, read return and clear control.
// The master drives requests; the slave (the RAM) returns dob/dob_valid/busy.
interface sdp_ram_neg_clr_if #(
  parameter int DATAW = 8,
  parameter int LANEW = 8,
  parameter int ADDRL = 14
);
  localparam int NLANE = DATAW / LANEW;

  logic             ena;
  logic             wea;
  logic [NLANE-1:0] wmask;
  logic [ADDRL-1:0] addra;
  logic [DATAW-1:0] dia;
  logic             enb;
  logic [ADDRL-1:0] addrb;
  logic [DATAW-1:0] dob;
  logic             dob_valid;
  logic             clr_req;
  logic             busy;

  modport master (
    output ena, wea, wmask, addra, dia, enb, addrb, clr_req,
    input  dob, dob_valid, busy
  );

  modport slave (
    input  ena, wea, wmask, addra, dia, enb, addrb, clr_req,
    output dob, dob_valid, busy
  );
endinterface

// File: rtl/sdp_ram_neg_clr.sv
// Negedge simple dual-port RAM with lane mask, RD_LAT 1/2 read, optional write-first bypass, INIT clear sweep.
// No backpressure: reads/writes issued while busy are dropped; reads stream one per negedge.
module sdp_ram_neg_clr #(
  parameter int               DATAW  = 8,
  parameter int               LANEW  = 8,
  parameter int               ADDRL  = 14,
  parameter logic [DATAW-1:0] INIT   = DATAW'(1),
  parameter int               RD_LAT = 1,
  parameter int               BYPASS = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  sdp_ram_neg_clr_if.slave    bus
);
  localparam int NLANE = DATAW / LANEW;
  localparam int DEPTH = 1 << ADDRL;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  logic [DATAW-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [ADDRL-1:0] cptr_q, cptr_d;
  logic [DATAW-1:0] dob_q, dob_d;
  logic             vld_q, vld_d;
  logic [DATAW-1:0] stg_dat_q, stg_dat_d;
  logic             stg_vld_q, stg_vld_d;

  logic             clearing;
  logic             user_wr;
  logic             user_rd;
  logic [DATAW-1:0] rd_raw;
  logic [DATAW-1:0] rd_dat;
  logic             wr_en;
  logic [ADDRL-1:0] wr_addr;
  logic [DATAW-1:0] wr_dat;
  logic [NLANE-1:0] wr_be;

  assign clearing = (state_q == S_CLEAR);
  assign user_wr  = !clearing && bus.ena && bus.wea;
  assign user_rd  = !clearing && bus.enb;
  assign rd_raw   = mem[bus.addrb];

  // Write-first view of a colliding read; pre-write data is what the array holds until the negedge.
  always_comb begin
    rd_dat = rd_raw;
    if (BYPASS != 0 && user_wr && bus.addra == bus.addrb) begin
      for (int i = 0; i < NLANE; i++) begin
        if (bus.wmask[i]) rd_dat[i*LANEW +: LANEW] = bus.dia[i*LANEW +: LANEW];
      end
    end
  end

  // Array write port is shared between the sweep and the user; held off while reset is asserted.
  always_comb begin
    wr_en   = rst_n && (clearing || user_wr);
    wr_addr = clearing ? cptr_q : bus.addra;
    wr_dat  = clearing ? INIT : bus.dia;
    wr_be   = clearing ? {NLANE{1'b1}} : bus.wmask;
  end

  always_ff @(negedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NLANE; i++) begin
        if (wr_be[i]) mem[wr_addr][i*LANEW +: LANEW] <= wr_dat[i*LANEW +: LANEW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cptr_d  = cptr_q;
    case (state_q)
      S_CLEAR: begin
        cptr_d = cptr_q + ADDRL'(1);
        if (cptr_q == {ADDRL{1'b1}}) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.clr_req) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    stg_dat_d = user_rd ? rd_dat : stg_dat_q;
    stg_vld_d = user_rd;
    dob_d     = dob_q;
    vld_d     = 1'b0;
    if (RD_LAT == 2) begin
      // Stage drains regardless of state so a read in flight at clear start still returns.
      if (stg_vld_q) dob_d = stg_dat_q;
      vld_d = stg_vld_q;
    end else begin
      if (user_rd) dob_d = rd_dat;
      vld_d = user_rd;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      cptr_q    <= '0;
      dob_q     <= '0;
      vld_q     <= 1'b0;
      stg_dat_q <= '0;
      stg_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cptr_q    <= cptr_d;
      dob_q     <= dob_d;
      vld_q     <= vld_d;
      stg_dat_q <= stg_dat_d;
      stg_vld_q <= stg_vld_d;
    end
  end

  assign bus.dob       = dob_q;
  assign bus.dob_valid = vld_q;
  assign bus.busy      = clearing;
endmodule

// File: tb/tb_sdp_ram_neg_clr.sv
// Two RAM configs (RD_LAT=1/read-first and RD_LAT=2/write-first) driven with identical directed vectors;
// read returns are checked by a queue scoreboard that also checks the negedge on which each one lands.
module tb_sdp_ram_neg_clr;
  localparam int DW = 32;
  localparam int AW = 4;

  typedef struct {
    logic [DW-1:0] dat;
    int            neg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   ncyc;
  int   errors;
  int   checks;
  exp_t qa[$];
  exp_t qb[$];

  sdp_ram_neg_clr_if #(.DATAW(DW), .LANEW(8), .ADDRL(AW)) ia ();
  sdp_ram_neg_clr_if #(.DATAW(DW), .LANEW(8), .ADDRL(AW)) ib ();

  sdp_ram_neg_clr #(.DATAW(DW), .LANEW(8), .ADDRL(AW), .INIT(32'h1), .RD_LAT(1), .BYPASS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );
  sdp_ram_neg_clr #(.DATAW(DW), .LANEW(8), .ADDRL(AW), .INIT(32'h1), .RD_LAT(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ncyc = 0;
  always @(negedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit we, input logic [3:0] m, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit re, input logic [AW-1:0] ra, input bit clr);
    ia.ena = we;  ia.wea = we;  ia.wmask = m;  ia.addra = wa;  ia.dia = wd;
    ia.enb = re;  ia.addrb = ra;  ia.clr_req = clr;
    ib.ena = we;  ib.wea = we;  ib.wmask = m;  ib.addra = wa;  ib.dia = wd;
    ib.enb = re;  ib.addrb = ra;  ib.clr_req = clr;
  endtask

  task automatic drive_idle();
    drive(1'b0, 4'h0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // Called at a posedge; the op is sampled on the following negedge.
  task automatic op(input bit we, input logic [3:0] m, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input bit re, input logic [AW-1:0] ra, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                    input bit clr);
    drive(we, m, wa, wd, re, ra, clr);
    if (re) begin
      qa.push_back('{dat: ea, neg: ncyc + 1});
      qb.push_back('{dat: eb, neg: ncyc + 2});
    end
    @(posedge clk);
    drive_idle();
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [3:0] m);
    op(1'b1, m, wa, wd, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] ra, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    op(1'b0, 4'h0, '0, '0, 1'b1, ra, ea, eb, 1'b0);
  endtask

  // Counts clear-write negedges for each DUT; whatever was driven is withdrawn after the first one.
  task automatic count_clear(output int na, output int nb);
    int  guard;
    bit  ba, bb;
    na = 0; nb = 0; guard = 0;
    while ((ia.busy || ib.busy) && guard < 100) begin
      ba = ia.busy; bb = ib.busy;
      @(negedge clk);
      if (ba) na++;
      if (bb) nb++;
      guard++;
      @(posedge clk);
      if (guard == 1) drive_idle();
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      if (ia.dob_valid) begin
        if (qa.size() == 0) chk("a_unexpected_valid", ia.dob, 32'hx);
        else begin
          e = qa.pop_front();
          chk("a_dob", ia.dob, e.dat);
          chk("a_latency", DW'(ncyc), DW'(e.neg));
        end
      end
      if (ib.dob_valid) begin
        if (qb.size() == 0) chk("b_unexpected_valid", ib.dob, 32'hx);
        else begin
          e = qb.pop_front();
          chk("b_dob", ib.dob, e.dat);
          chk("b_latency", DW'(ncyc), DW'(e.neg));
        end
      end
    end
  endtask

  initial begin
    int na, nb;
    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    drive_idle();
    #1 rst_n = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    chk("rst_a_dob", ia.dob, 32'h0);
    chk("rst_b_dob", ib.dob, 32'h0);
    chk("rst_a_valid", DW'(ia.dob_valid), 32'h0);
    chk("rst_b_valid", DW'(ib.dob_valid), 32'h0);
    chk("rst_a_busy", DW'(ia.busy), 32'h1);
    chk("rst_b_busy", DW'(ib.busy), 32'h1);

    rst_n = 1'b1;
    count_clear(na, nb);
    chk("clear_len_a", DW'(na), 32'd16);
    chk("clear_len_b", DW'(nb), 32'd16);

    for (int i = 0; i < 16; i++) rd(AW'(i), 32'h1, 32'h1);

    wr(4'd3, 32'hDEADBEEF, 4'hF);
    wr(4'd3, 32'h11223344, 4'h5);
    rd(4'd3, 32'hDE22BE44, 32'hDE22BE44);

    wr(4'd7, 32'h000000AA, 4'hF);
    op(1'b1, 4'hF, 4'd7, 32'h00000055, 1'b1, 4'd7, 32'h000000AA, 32'h00000055, 1'b0);
    rd(4'd7, 32'h00000055, 32'h00000055);
    op(1'b1, 4'h3, 4'd7, 32'h12345678, 1'b1, 4'd7, 32'h00000055, 32'h00005678, 1'b0);
    rd(4'd7, 32'h00005678, 32'h00005678);

    wr(4'd0, 32'h10, 4'hF);
    wr(4'd1, 32'h11, 4'hF);
    wr(4'd2, 32'h12, 4'hF);
    wr(4'd0, 32'hFFFFFFFF, 4'h0);
    rd(4'd0, 32'h10, 32'h10);
    rd(4'd1, 32'h11, 32'h11);
    rd(4'd2, 32'h12, 32'h12);
    repeat (3) @(posedge clk);

    // Clear request with a same-negedge write and read, then traffic that must be dropped.
    op(1'b1, 4'hF, 4'd9, 32'h99, 1'b1, 4'd3, 32'hDE22BE44, 32'hDE22BE44, 1'b1);
    drive(1'b1, 4'hF, 4'd5, 32'h77, 1'b1, 4'd5, 1'b0);
    count_clear(na, nb);
    chk("clr_len_a", DW'(na), 32'd16);
    chk("clr_len_b", DW'(nb), 32'd16);
    rd(4'd5, 32'h1, 32'h1);
    rd(4'd9, 32'h1, 32'h1);
    repeat (3) @(posedge clk);

    // Reset with cptr at 9.
    op(1'b0, 4'h0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    repeat (9) @(posedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_a_dob", ia.dob, 32'h0);
    chk("midrst_b_dob", ib.dob, 32'h0);
    chk("midrst_a_busy", DW'(ia.busy), 32'h1);
    chk("midrst_b_busy", DW'(ib.busy), 32'h1);
    @(posedge clk);
    rst_n = 1'b1;
    count_clear(na, nb);
    chk("reclear_len_a", DW'(na), 32'd16);
    chk("reclear_len_b", DW'(nb), 32'd16);
    rd(4'd7, 32'h1, 32'h1);

    repeat (4) @(posedge clk);
    chk("qa_drained", DW'(qa.size()), 32'h0);
    chk("qb_drained", DW'(qb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdp_ram_neg_clr.md
# sdp_ram_neg_clr

Parametrised simple dual-port RAM, all storage updated on the falling edge of `clk`, with per-lane write mask, selectable read latency, optional write-to-read bypass and a hardware clear sequencer. It is the next generation of the team's byte-wide, fixed-init negedge frame/line buffers. After every reset and on request, it fills the whole array with `INIT`, so software never depends on simulation-only initial blocks.

## Interface
Parameters:
- `DATAW`, 8, data width in bits; must be a multiple of `LANEW`.
- `LANEW`, 8, write-mask lane width.
- `ADDRL`, 14, address width; depth = 2^ADDRL.
- `INIT`, 1, value written to every word by the clear sequencer, zero-extended or truncated to `DATAW`.
- `RD_LAT`, 1, read latency in negedges; legal values are 1 or 2.
- `BYPASS`, 0, read/write collision policy: 0 = read-first (old data), 1 = write-first (new data merged through the mask).

Ports:
- `clk`  in  1  single clock; all state changes on negedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  write-port enable.
- `wea`  in  1  write strobe; qualified by `ena`.
- `wmask`  in  DATAW/LANEW  per-lane write enable.
- `addra`  in  ADDRL  write address.
- `dia`  in  DATAW  write data.
- `enb`  in  1  read request.
- `addrb`  in  ADDRL  read address.
- `dob`  out  DATAW  read data.
- `dob_valid`  out  1  one-negedge-wide pulse, coincident with new `dob`.
- `clr_req`  in  1  clear request; sampled at negedge.
- `busy`  out  1  high while the clear sequencer owns the array.

## Operation
- The FSM has two states, CLEAR and IDLE. A clear pointer `cptr` is ADDRL bits wide.
- Reset (asynchronous on `rst_n` low) forces:
  - state = CLEAR, `cptr` = 0, `busy` = 1;
  - `dob` = 0, `dob_valid` = 0, and the RD_LAT=2 stage register = 0 with its valid cleared.
- Reset does not touch array contents.
- In CLEAR, each negedge writes `INIT` to `ram[cptr]` with all lanes and increments `cptr`.
  - On the negedge that writes address 2^ADDRL−1: `cptr` wraps to 0, state becomes IDLE, `busy` is set to 0.
- In CLEAR, `ena`/`wea`/`enb`/`clr_req` are ignored. No write occurs and no `dob_valid` is produced. Requests are dropped, not queued.
- In IDLE, `clr_req`=1 at a negedge moves to CLEAR and sets `busy`=1. The first clear write happens on the following negedge.
  - A user write or read presented on that same negedge is still performed.
- Write: in IDLE, when `ena & wea` are high, each lane i with `wmask[i]`=1 updates `ram[addra]` bits [i*LANEW +: LANEW] from `dia`. Other lanes hold.
  - `wmask` = 0 is a legal no-op.
- Read: in IDLE, when `enb`=1, `ram[addrb]` is captured. `enb` does not depend on `ena`.
- Collision (same negedge, `ena&wea&enb`, `addra==addrb`):
  - BYPASS=0 returns pre-write data;
  - BYPASS=1 returns old data with the masked lanes replaced by `dia`.
- `dob` holds its last value when no read completes. `dob_valid` is 0 in that case.

## Timing
- RD_LAT=1: a read sampled at negedge N gives `dob`/`dob_valid` updated at negedge N. They are visible for the next full cycle.
- RD_LAT=2: the read is captured into the stage register at negedge N and presented on `dob`/`dob_valid` at negedge N+1.
  - Back-to-back reads are accepted every negedge (full throughput).
- A read in flight in the RD_LAT=2 stage when a clear begins still completes at N+1.
- Write-to-read of the same address on a later negedge always returns the new data, independent of BYPASS.
- Clear duration: exactly 2^ADDRL negedges from the first clear write.
  - After reset, the first clear write is the first negedge with `rst_n` high.
  - The first user operation is accepted at the negedge after `busy` falls.
- `rst_n` asserted mid-clear aborts the sweep. After deassertion, the clear restarts at address 0.
- `clr_req` held high continuously: after each sweep completes, one IDLE negedge accepts user operations and also re-enters CLEAR.

## Test plan
- Reset and clear with ADDRL=4, INIT=1, RD_LAT=1:
  - release `rst_n` → `busy` high for exactly 16 negedges;
  - then read addresses 0..15 → `dob`=0x01 each, `dob_valid` pulsed once per read.
- Masked write with DATAW=32, LANEW=8:
  - write 0xDEADBEEF with mask 0xF, then 0x11223344 with mask 0x5 to address 3;
  - read address 3 → 0xDE22BE44.
- Collision on address 7 (old value 0xAA, write 0x55, mask all ones):
  - BYPASS=0 → `dob`=0xAA, then re-read → 0x55;
  - BYPASS=1 → `dob`=0x55.
- RD_LAT=2 streaming: reads of addresses 0,1,2 on consecutive negedges, with preloaded values 0x10, 0x11, 0x12 → `dob` = 0x10, 0x11, 0x12 on negedges N+1..N+3, with `dob_valid` high for 3 consecutive negedges.
- Blocked access during clear:
  - `clr_req` pulse, then a write of 0x77 to address 5 during `busy` → write dropped, no `dob_valid` during `busy`;
  - after the clear, address 5 reads INIT.
- Reset mid-clear: assert `rst_n` low at `cptr`=9 → `dob`=0, `busy`=1, and after release the sweep again takes a full 16 negedges.
